load_store_unit: RTL

Initiator-side memory access controller between the MEM stage and the doubleword-wide `data_memory`. It accepts one load or store per handshake and decodes the RV64 funct3 size and signedness. It generates doubleword-indexed read/write strobes and performs read-modify-write for byte, half and word stores. Loads are returned sign- or zero-extended, with alignment and range errors reported.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_if.sv | 18 +
 rtl/lsu_align.sv | 24 ++
 rtl/load_store_unit.sv | 68 ++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, funct3 codes and size/legality decode for the load/store unit
package lsu_pkg;
  localparam int DEF_DMEM_DEPTH = 1024;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  function automatic logic [3:0] f3_size(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction
  // Stores have no unsigned variants; loads lack only 111.
  function automatic logic f3_illegal(input logic wr, input logic [2:0] f3);
    return wr ? f3[2] : f3 == 3'b111;
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: MEM-stage request/response handshake between pipeline (master) and load/store unit (slave)
// req_*: valid/ready handshake with write flag, funct3, byte address, store data
// resp_*: single-cycle response pulse with extended load data and error flag
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  modport master (output req_valid, req_write, req_funct3, req_addr, req_wdata,
                  input  req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_write, req_funct3, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: little-endian byte-lane merge for sub-doubleword stores and sign/zero extension for loads
// offset/funct3: access position and size; old: doubleword read from memory; wdata: store data
// merged: old with the addressed lanes replaced; load_val: extended load result
module lsu_align (
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [63:0] old,
  input  logic [63:0] wdata,
  output logic [63:0] merged,
  output logic [63:0] load_val
);
  logic [5:0]  sh;
  logic [63:0] lane, shifted;
  assign sh = {offset, 3'b000};
  assign lane = funct3[1:0] == 2'd0 ? 64'hFF :
                funct3[1:0] == 2'd1 ? 64'hFFFF :
                funct3[1:0] == 2'd2 ? 64'hFFFF_FFFF : '1;
  assign merged = (old & ~(lane << sh)) | ((wdata & lane) << sh);
  assign shifted = old >> sh;
  assign load_val = funct3[2]           ? shifted & lane :
                    funct3[1:0] == 2'd0 ? {{56{shifted[7]}}, shifted[7:0]} :
                    funct3[1:0] == 2'd1 ? {{48{shifted[15]}}, shifted[15:0]} :
                    funct3[1:0] == 2'd2 ? {{32{shifted[31]}}, shifted[31:0]} : shifted;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store controller with read-modify-write for narrow stores
// clk, rst_n: clock and async active-low reset; bus: request/response handshake (slave)
// mem_addr/mem_wdata/mem_read/mem_write/mem_rdata: doubleword-indexed data memory port
module load_store_unit import lsu_pkg::*; #(
  parameter int DMEM_DEPTH = DEF_DMEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_if.slave        bus,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_rdata
);
  localparam logic [1:0] IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] READ  = 2'(ST_READ);
  localparam logic [1:0] WRITE = 2'(ST_WRITE);
  localparam logic [1:0] RESP  = 2'(ST_RESP);
  logic [1:0]  state;
  logic        wr_q, err_q, err_c, sd_q;
  logic [2:0]  f3_q;
  logic [63:0] addr_q, wdata_q, rdata_q, merged, load_val;
  assign err_c = |(bus.req_addr[2:0] & 3'(f3_size(bus.req_funct3) - 4'd1))
               | (bus.req_addr[63:3] >= 61'(DMEM_DEPTH))
               | f3_illegal(bus.req_write, bus.req_funct3);
  assign sd_q = wr_q && f3_q[1:0] == 2'b11;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        wr_q    <= bus.req_write;
        err_q   <= err_c;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == READ) rdata_q <= mem_rdata;
      // Full-doubleword stores skip the read; narrow stores read first to merge.
      state <= state == IDLE  ? (!bus.req_valid ? IDLE : err_c ? RESP :
                                 (bus.req_write && bus.req_funct3[1:0] == 2'b11) ? WRITE : READ) :
               state == READ  ? (wr_q ? WRITE : RESP) :
               state == WRITE ? RESP : IDLE;
    end
  lsu_align u_align (
    .offset   (addr_q[2:0]),
    .funct3   (f3_q),
    .old      (rdata_q),
    .wdata    (wdata_q),
    .merged   (merged),
    .load_val (load_val)
  );
  assign bus.req_ready  = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_err   = state == RESP && err_q;
  assign bus.resp_rdata = (state == RESP && !err_q && !wr_q) ? load_val : '0;
  assign mem_read  = state == READ;
  assign mem_write = state == WRITE;
  assign mem_addr  = state == IDLE ? '0 : {3'b000, addr_q[63:3]};
  assign mem_wdata = state == WRITE ? (sd_q ? wdata_q : merged) : '0;
endmodule
